// File: rtl/friscv_pkg.sv
// Shared definitions for the friscv core and its boot-time instruction loader.
package friscv_pkg;

    localparam int unsigned ARCH             = 32;
    localparam int unsigned LOADER_LEN_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts accepted bytes into an instruction word, little-endian, and counts bytes per word.
module word_assembler #(
    parameter int unsigned ARCH = friscv_pkg::ARCH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_shift,
    input  logic [7:0]      i_byte,
    output logic [ARCH-1:0] o_word,
    output logic            o_full_c
);

    localparam int unsigned BYTES = ARCH / 8;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [ARCH-1:0] r_word;
    logic [CW-1:0]   r_cnt;

    // New bytes enter at the top so the first byte of a word lands in bits 7:0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= {i_byte, r_word[ARCH-1:8]};
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_full_c = i_shift && (r_cnt == CW'(BYTES - 1));
    assign o_word   = r_word;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory while holding the core in reset.
module imem_loader
    import friscv_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 4096,
    parameter int unsigned ARCH       = friscv_pkg::ARCH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_in,
    input  logic                          byte_valid_in,
    input  logic [7:0]                    byte_data_in,
    output logic                          byte_ready_out,
    output logic                          imem_we_out,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_out,
    output logic [ARCH-1:0]               imem_wdata_out,
    output logic                          core_rst_n_out,
    output logic                          done_out,
    output logic                          err_out
);

    localparam int unsigned AW        = $clog2(IMEM_DEPTH);
    localparam int unsigned LW        = 8 * LOADER_LEN_BYTES;
    localparam int unsigned MAX_WORDS = IMEM_DEPTH / 4;

    loader_state_t r_state, w_state_nx;

    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_widx;
    logic [7:0]      r_cks;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic            r_ready;
    logic            r_core_rst_n;
    logic            r_done;
    logic            r_err;

    logic            w_accept;
    logic            w_shift;
    logic            w_clear;
    logic            w_we_nx;
    logic            w_ready_nx;
    logic            w_full;
    logic [LW-1:0]   w_len_full;
    logic [ARCH-1:0] w_word;

    assign w_accept   = byte_valid_in && r_ready;
    assign w_shift    = w_accept && (r_state == DATA);
    assign w_len_full = {byte_data_in, r_len[7:0]};

    word_assembler #(.ARCH(ARCH)) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_shift  (w_shift),
        .i_byte   (byte_data_in),
        .o_word   (w_word),
        .o_full_c (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_we_nx    = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start_in) begin
                    w_state_nx = LEN_LO;
                    w_clear    = 1'b1;
                end
            end
            LEN_LO: if (w_accept) w_state_nx = LEN_HI;
            LEN_HI: begin
                if (w_accept) begin
                    if (32'(w_len_full) > 32'(MAX_WORDS)) w_state_nx = ERROR;
                    else if (w_len_full == '0)            w_state_nx = CHECK;
                    else                                  w_state_nx = DATA;
                end
            end
            // The write-pulse cycle stays in DATA with ready low; the last write moves on to CHECK.
            DATA: begin
                if (r_we) begin
                    if (r_widx + LW'(1) == r_len) w_state_nx = CHECK;
                end else if (w_full) begin
                    w_we_nx = 1'b1;
                end
            end
            CHECK: begin
                if (w_accept) w_state_nx = (byte_data_in == r_cks) ? DONE : ERROR;
            end
            default: w_state_nx = IDLE;
        endcase
        w_ready_nx = !w_we_nx && ((w_state_nx == LEN_LO) || (w_state_nx == LEN_HI) ||
                                  (w_state_nx == DATA)   || (w_state_nx == CHECK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_widx       <= '0;
            r_cks        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_ready      <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we         <= w_we_nx;
            r_ready      <= w_ready_nx;
            r_core_rst_n <= (w_state_nx == DONE);
            r_done       <= (w_state_nx == DONE);
            r_err        <= (w_state_nx == ERROR);
            if (w_clear) begin
                r_len  <= '0;
                r_widx <= '0;
                r_cks  <= '0;
            end else begin
                if (w_accept && (r_state == LEN_LO)) r_len[7:0]  <= byte_data_in;
                if (w_accept && (r_state == LEN_HI)) r_len[15:8] <= byte_data_in;
                if (w_shift)                         r_cks       <= r_cks ^ byte_data_in;
                if (r_we)                            r_widx      <= r_widx + LW'(1);
            end
            if (w_we_nx) r_addr <= AW'({r_widx, 2'b00});
        end
    end

    assign byte_ready_out = r_ready;
    assign imem_we_out    = r_we;
    assign imem_addr_out  = r_addr;
    assign imem_wdata_out = w_word;
    assign core_rst_n_out = r_core_rst_n;
    assign done_out       = r_done;
    assign err_out        = r_err;

endmodule
